// File: rtl/lbm_divider.sv
// ----------------------------------------------------------------------------
// lbm_divider
//   Signed fixed-point divider for the LBM velocity path: computes
//   (dividend * 2^FRAC_BITS) / divisor, truncated toward zero, with saturation
//   and a divide-by-zero flag. It uses a restoring division on magnitudes,
//   producing one quotient bit per clock. The latency is fixed at
//   DATA_WIDTH+FRAC_BITS+1 cycles from the start edge to div_valid.
//
// Ports
//   Clk          : clock, all state changes on the rising edge
//   Reset        : asynchronous active-low reset
//   div_start    : start request; operands are sampled on the same edge (IDLE only)
//   dividend     : signed numerator, two's complement
//   divisor      : signed denominator, two's complement
//   quotient     : signed registered result, held until the next result
//   div_valid    : one-cycle pulse; quotient/div_by_zero are valid while high
//   div_busy     : high in every state except IDLE
//   div_by_zero  : registered flag for the divisor == 0 case
// ----------------------------------------------------------------------------
module lbm_divider #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic                  div_valid,
    output logic                  div_busy,
    output logic                  div_by_zero
);

    localparam int N  = DATA_WIDTH + FRAC_BITS;   // iterations / quotient bits
    localparam int CW = $clog2(N);

    localparam logic [DATA_WIDTH-1:0] Q_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] Q_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_cnt;
    // Holds the shifted numerator. Quotient bits shift in from the bottom as
    // numerator bits leave the top, so after N iterations it holds the quotient.
    logic [N-1:0]            r_num;
    logic [DATA_WIDTH-1:0]   r_rem;
    logic [DATA_WIDTH-1:0]   r_den;
    logic                    r_neg;
    logic                    r_dvd_neg;
    logic                    r_dvd_zero;
    logic                    r_zero_div;
    logic [DATA_WIDTH-1:0]   r_quotient;
    logic                    r_dbz;

    logic [DATA_WIDTH-1:0]   w_abs_dvd;
    logic [DATA_WIDTH-1:0]   w_abs_dsr;
    logic [N-1:0]            w_num_init;
    logic [DATA_WIDTH:0]     w_trial;
    logic [DATA_WIDTH:0]     w_diff;
    logic                    w_fits;
    logic                    w_ovf_pos;
    logic                    w_ovf_neg;
    logic [DATA_WIDTH-1:0]   w_q_low;
    logic [DATA_WIDTH-1:0]   w_fix_q;

    // The unsigned magnitude of the most negative value is 2^(DATA_WIDTH-1).
    // That value still fits in DATA_WIDTH unsigned bits, so no extra bit is needed.
    assign w_abs_dvd  = dividend[DATA_WIDTH-1] ? (~dividend + 1'b1) : dividend;
    assign w_abs_dsr  = divisor[DATA_WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
    assign w_num_init = N'(w_abs_dvd) << FRAC_BITS;

    // Restoring step. The partial remainder is always below the divisor, so the
    // trial value needs only one extra bit. The top bit of the difference is the borrow.
    assign w_trial = {r_rem, r_num[N-1]};
    assign w_diff  = w_trial - {1'b0, r_den};
    assign w_fits  = ~w_diff[DATA_WIDTH];

    // A positive result overflows above 2^(DW-1)-1. A negative result may reach
    // exactly 2^(DW-1) in magnitude before it overflows.
    assign w_q_low   = r_num[DATA_WIDTH-1:0];
    assign w_ovf_pos = |r_num[N-1:DATA_WIDTH-1];
    assign w_ovf_neg = (|r_num[N-1:DATA_WIDTH]) |
                       (r_num[DATA_WIDTH-1] & (|r_num[DATA_WIDTH-2:0]));

    always_comb begin
        w_fix_q = w_q_low;
        if (r_zero_div) begin
            if (r_dvd_zero)     w_fix_q = '0;
            else if (r_dvd_neg) w_fix_q = Q_MIN;
            else                w_fix_q = Q_MAX;
        end else if (r_neg) begin
            // Negating a zero magnitude gives 0, so a result of -0 never appears.
            w_fix_q = w_ovf_neg ? Q_MIN : (~w_q_low + 1'b1);
        end else begin
            w_fix_q = w_ovf_pos ? Q_MAX : w_q_low;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (div_start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == CW'(N-1)) w_state_next = S_FIX;
            S_FIX:   w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt      <= '0;
            r_num      <= '0;
            r_rem      <= '0;
            r_den      <= '0;
            r_neg      <= 1'b0;
            r_dvd_neg  <= 1'b0;
            r_dvd_zero <= 1'b0;
            r_zero_div <= 1'b0;
            r_quotient <= '0;
            r_dbz      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (div_start) begin
                        r_cnt      <= '0;
                        r_num      <= w_num_init;
                        r_rem      <= '0;
                        r_den      <= w_abs_dsr;
                        r_neg      <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
                        r_dvd_neg  <= dividend[DATA_WIDTH-1];
                        r_dvd_zero <= (dividend == '0);
                        r_zero_div <= (divisor == '0);
                    end
                end
                S_RUN: begin
                    r_num <= {r_num[N-2:0], w_fits};
                    r_rem <= w_fits ? w_diff[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    r_quotient <= w_fix_q;
                    r_dbz      <= r_zero_div;
                end
                default: ;
            endcase
        end
    end

    assign quotient    = r_quotient;
    assign div_by_zero = r_dbz;
    assign div_valid   = (r_state == S_DONE);
    assign div_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_lbm_divider.sv
// ----------------------------------------------------------------------------
// tb_lbm_divider
//   Directed and randomized checks of lbm_divider at the default Q16.16
//   configuration. A scoreboard queue holds the expected result and start
//   cycle of each launched division. Entries are popped and compared when
//   div_valid appears.
// ----------------------------------------------------------------------------
module tb_lbm_divider;

    localparam int LAT = 49;

    logic        Clk;
    logic        Reset;
    logic        div_start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic        div_valid;
    logic        div_busy;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic        dbz;
        int          start;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    lbm_divider #(.DATA_WIDTH(32), .FRAC_BITS(16)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .div_start  (div_start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .div_valid  (div_valid),
        .div_busy   (div_busy),
        .div_by_zero(div_by_zero)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic in 64 bits, then clamp to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic dbz);
        longint num, res;
        dbz = (b == 32'd0);
        if (dbz) begin
            if (a == 32'd0)      q = 32'h0000_0000;
            else if ($signed(a) > 0) q = 32'h7FFF_FFFF;
            else                 q = 32'h8000_0000;
        end else begin
            num = longint'($signed(a)) * 64'sd65536;
            res = num / longint'($signed(b));
            if (res > 64'sd2147483647)        q = 32'h7FFF_FFFF;
            else if (res < -64'sd2147483648)  q = 32'h8000_0000;
            else                              q = res[31:0];
        end
    endfunction

    // Drive one start edge and push the expected result.
    // Operands are scrambled right after the start edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic edbz);
        exp_t e;
        @(negedge Clk);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(negedge Clk);
        div_start = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        e.q = eq; e.dbz = edbz; e.start = cyc;
        sb.push_back(e);
        check("busy_after_start", 64'(div_busy), 64'd1);
    endtask

    // Wait (bounded) for div_valid, then compare against the oldest scoreboard entry.
    task automatic collect(input string tag);
        exp_t e;
        bit   got = 1'b0;
        int   lat = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge Clk);
            if (div_valid === 1'b1) got = 1'b1;
        end
        lat = cyc;
        check({tag, "_valid_seen"}, 64'(got), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            if (got) begin
                check({tag, "_latency"}, 64'(lat - e.start), 64'(LAT));
                check({tag, "_quotient"}, 64'(quotient), 64'(e.q));
                check({tag, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
                @(negedge Clk);
                check({tag, "_pulse_width"}, 64'(div_valid), 64'd0);
                check({tag, "_q_hold"}, 64'(quotient), 64'(e.q));
            end
        end
        $display("tb: %s done at cycle %0d quotient=%08h dbz=%0d", tag, cyc, quotient, div_by_zero);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic edbz, input string tag);
        launch(a, b, eq, edbz);
        collect(tag);
    endtask

    initial begin
        logic [31:0] ra, rb, rq;
        logic        rdbz;
        exp_t        e;
        int          s0;
        int          spurious;

        Reset     = 1'b1;
        div_start = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #2 Reset = 1'b0;
        #1;
        check("reset_quotient", 64'(quotient), 64'd0);
        check("reset_valid", 64'(div_valid), 64'd0);
        check("reset_busy", 64'(div_busy), 64'd0);
        check("reset_dbz", 64'(div_by_zero), 64'd0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;

        // Directed vectors
        run(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, "one_over_two");
        run(32'hFFFD_0000, 32'h0002_0000, 32'hFFFE_8000, 1'b0, "neg3_over_2");
        run(32'h0001_0000, 32'hFFFD_0000, 32'hFFFF_AAAB, 1'b0, "one_over_neg3");
        run(32'h0007_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, "pos_div0");
        run(32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, "zero_div0");
        run(32'hFFF9_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, "neg_div0");
        run(32'h7FFF_0000, 32'h0000_0100, 32'h7FFF_FFFF, 1'b0, "sat_pos");
        run(32'h8000_0000, 32'h0000_0100, 32'h8000_0000, 1'b0, "sat_neg");
        run(32'h0000_0001, 32'hFFFD_0000, 32'h0000_0000, 1'b0, "neg_zero");
        run(32'h8000_0000, 32'h8000_0000, 32'h0001_0000, 1'b0, "min_over_min");
        run(32'hC000_0000, 32'h0001_0000, 32'hC000_0000, 1'b0, "exact_neg_limit");

        // Random vectors against the reference model
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            ra = $signed(ra) >>> $urandom_range(0, 16);
            rb = $urandom;
            rb = $signed(rb) >>> $urandom_range(4, 24);
            model(ra, rb, rq, rdbz);
            run(ra, rb, rq, rdbz, $sformatf("rand%0d", i));
        end

        // Second start while busy is ignored
        launch(32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0);
        repeat (9) begin
            @(negedge Clk);
            check("busy_during_run", 64'(div_busy), 64'd1);
        end
        @(negedge Clk);
        dividend  = 32'h0001_0000;
        divisor   = 32'h0004_0000;
        div_start = 1'b1;
        @(negedge Clk);
        div_start = 1'b0;
        check("busy_after_ignored_start", 64'(div_busy), 64'd1);
        collect("ignored_start");
        spurious = 0;
        repeat (60) begin
            @(negedge Clk);
            if (div_valid === 1'b1) spurious++;
        end
        check("no_second_pulse", 64'(spurious), 64'd0);

        // Back-to-back with start held high: the period is N+3 = 51 cycles
        @(negedge Clk);
        dividend  = 32'h0001_0000;
        divisor   = 32'h0002_0000;
        div_start = 1'b1;
        @(negedge Clk);
        s0 = cyc;
        e.q = 32'h0000_8000; e.dbz = 1'b0; e.start = s0;
        sb.push_back(e);
        e.q = 32'h0002_8000; e.dbz = 1'b0; e.start = s0 + 51;
        sb.push_back(e);
        collect("b2b_first");
        dividend = 32'h0005_0000;
        divisor  = 32'h0002_0000;
        collect("b2b_second");
        div_start = 1'b0;
        repeat (2) @(negedge Clk);
        check("b2b_idle_after_stop", 64'(div_busy), 64'd0);

        // Reset 20 cycles into a division aborts it asynchronously
        @(negedge Clk);
        dividend  = 32'h0001_0000;
        divisor   = 32'h0002_0000;
        div_start = 1'b1;
        @(negedge Clk);
        div_start = 1'b0;
        repeat (19) @(negedge Clk);
        Reset = 1'b0;
        #1;
        check("abort_quotient", 64'(quotient), 64'd0);
        check("abort_valid", 64'(div_valid), 64'd0);
        check("abort_busy", 64'(div_busy), 64'd0);
        check("abort_dbz", 64'(div_by_zero), 64'd0);
        spurious = 0;
        repeat (3) begin
            @(negedge Clk);
            if (div_valid === 1'b1) spurious++;
        end
        Reset = 1'b1;
        repeat (60) begin
            @(negedge Clk);
            if (div_valid === 1'b1 || div_busy === 1'b1) spurious++;
        end
        check("abort_no_pulse", 64'(spurious), 64'd0);
        run(32'h0001_0000, 32'h0002_0000, 32'h0000_8000, 1'b0, "after_reset");

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lbm_divider.md
LBM_DIVIDER -- requirements
Module: lbm_divider

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and quotient width.
REQ-002 SHALL have parameter FRAC_BITS, default 16, fractional bits of the signed fixed-point format (Q16.16 at defaults).
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port div_start  input  1  request from controller; operands sampled on the same edge.
REQ-006 SHALL have port dividend  input  DATA_WIDTH  signed two's complement numerator (density-weighted momentum, e.g. p*ux).
REQ-007 SHALL have port divisor  input  DATA_WIDTH  signed two's complement denominator (density p).
REQ-008 SHALL have port quotient  output  DATA_WIDTH  signed result, registered.
REQ-009 SHALL have port div_valid  output  1  one-cycle pulse; quotient valid while high.
REQ-010 SHALL have port div_busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port div_by_zero  output  1  registered flag, meaningful while div_valid is high.

Function
REQ-012 SHALL compute (dividend * 2^FRAC_BITS) / divisor, truncated toward zero.
REQ-013 SHALL use a sequential restoring algorithm on magnitudes: N = DATA_WIDTH+FRAC_BITS iterations, one quotient bit per cycle.
REQ-014 SHALL implement states IDLE, RUN, FIX, DONE.
REQ-015 IDLE: div_start=1 at an edge -> capture |dividend|, |divisor|, result sign (XOR of operand signs), zero-divisor flag; go to RUN; iteration counter cleared.
REQ-016 RUN: one iteration per edge; after the N-th iteration edge -> FIX.
REQ-017 FIX: apply sign, saturate, load quotient and div_by_zero; next edge -> DONE.
REQ-018 DONE: div_valid=1 for exactly one cycle; next edge -> IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge k -> div_valid high during the cycle after edge k+N+1 (49 cycles at defaults), independent of operand values.
REQ-020 Magnitudes SHALL be held in DATA_WIDTH-bit unsigned form so that the most negative operand (0x80000000) is handled without overflow.
REQ-021 If the true result exceeds 2^(DATA_WIDTH-1)-1 it SHALL saturate to 0x7FFFFFFF; if it is below -2^(DATA_WIDTH-1) it SHALL saturate to 0x80000000.
REQ-022 divisor=0 SHALL set div_by_zero=1 with fixed latency; quotient = 0x7FFFFFFF if dividend>0, 0x80000000 if dividend<0, 0 if dividend=0.
REQ-023 A result of -0 SHALL be output as 0x00000000.
REQ-024 div_start SHALL be ignored in RUN, FIX and DONE; operand changes after the start edge SHALL NOT affect the result.
REQ-025 div_start held high continuously SHALL start a new division on each return to IDLE (back-to-back period N+3 cycles).
REQ-026 quotient and div_by_zero SHALL hold their last values after div_valid deasserts, until the next FIX.

Reset
REQ-027 Reset=0 SHALL immediately force state IDLE, quotient=0, div_valid=0, div_busy=0, div_by_zero=0, counter=0, without waiting for Clk.
REQ-028 Reset asserted mid-division SHALL abort it with no div_valid pulse; the first start after release SHALL complete with full latency.

Verification
REQ-029 0x00010000 / 0x00020000 (1.0/2.0) -> quotient 0x00008000, div_by_zero=0, div_valid exactly 49 cycles after the start edge.
REQ-030 0xFFFD0000 / 0x00020000 (-3.0/2.0) -> 0xFFFE8000 (-1.5); 0x00010000 / 0xFFFD0000 -> 0xFFFFAAAB (truncated toward zero).
REQ-031 0x00070000 / 0 -> 0x7FFFFFFF, div_by_zero=1; 0 / 0 -> 0x00000000, div_by_zero=1; both with 49-cycle latency.
REQ-032 0x7FFF0000 / 0x00000100 -> 0x7FFFFFFF (positive saturation); 0x80000000 / 0x00000100 -> 0x80000000.
REQ-033 Second div_start with different operands 10 cycles after the first -> ignored; single div_valid pulse carrying the first result; div_busy high throughout.
REQ-034 Reset driven low 20 cycles into a division -> all outputs 0 asynchronously, no div_valid; new 1.0/2.0 request after release -> 0x00008000 at 49 cycles.
